mem_sequencer: RTL and testbench

//  Shares one single-port synchronous RAM between the CPU instruction port, the
//  CPU data port and a debug access port. Sequences each CPU step as fetch ->

---
 rtl/mem_sequencer.sv | 100 ++++++++++
 tb/tb_mem_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// mem_sequencer: arbitrates one single-port synchronous RAM between CPU fetch, CPU data and debug accesses
module mem_sequencer #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [29:0]          CPU_INST_ADDR,
    output logic [31:0]          CPU_INST_RD,
    input  logic                 CPU_DATA_REQ,
    input  logic                 CPU_DATA_WE,
    input  logic [3:0]           CPU_DATA_BE,
    input  logic [29:0]          CPU_DATA_ADDR,
    input  logic [31:0]          CPU_DATA_WD,
    output logic [31:0]          CPU_DATA_RD,
    output logic                 CPU_RUN,
    input  logic                 HALT,
    input  logic                 DBG_REQ,
    input  logic                 DBG_WE,
    input  logic [29:0]          DBG_ADDR,
    input  logic [31:0]          DBG_WD,
    output logic [31:0]          DBG_RD,
    output logic                 DBG_ACK,
    output logic                 MEM_EN,
    output logic                 MEM_WE,
    output logic [3:0]           MEM_BE,
    output logic [29:0]          MEM_ADDR,
    output logic [31:0]          MEM_WD,
    input  logic [31:0]          MEM_RD,
    output logic [CNT_WIDTH-1:0] INSTR_CNT
);
    localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {FETCH, FWAIT, DATA, DWAIT, COMMIT, DBGWAIT} state_t;

    state_t     state, state_d;
    logic [1:0] cnt;
    logic       dbg_turn, rd_q, done;
    logic       issue_dbg, issue_inst, issue_data;

    assign done = cnt == 2'd0;

    // State register
    always_ff @(posedge CLK) begin
        state <= !RESET ? FETCH : state_d;
    end

    // Next-state: each access waits MEM_LATENCY cycles in its *WAIT state
    always_comb begin
        state_d = state;
        unique case (state)
            FETCH:   state_d = issue_dbg ? DBGWAIT : issue_inst ? FWAIT : FETCH;
            FWAIT:   state_d = done ? DATA : FWAIT;
            DATA:    state_d = CPU_DATA_REQ ? DWAIT : COMMIT;
            DWAIT:   state_d = done ? COMMIT : DWAIT;
            COMMIT:  state_d = FETCH;
            DBGWAIT: state_d = done ? FETCH : DBGWAIT;
            default: state_d = FETCH;
        endcase
    end

    // Outputs: RAM strobes for the access issued this cycle, zeros when idle or in reset
    always_comb begin
        issue_dbg  = RESET && state == FETCH && DBG_REQ && (HALT || dbg_turn);
        issue_inst = RESET && state == FETCH && !issue_dbg && !HALT;
        issue_data = RESET && state == DATA && CPU_DATA_REQ;
        MEM_EN     = issue_dbg || issue_inst || issue_data;
        MEM_WE     = issue_dbg ? DBG_WE : (issue_data && CPU_DATA_WE);
        MEM_BE     = (issue_data && CPU_DATA_WE) ? CPU_DATA_BE : MEM_EN ? 4'hF : 4'h0;
        MEM_ADDR   = issue_dbg ? DBG_ADDR : issue_data ? CPU_DATA_ADDR : issue_inst ? CPU_INST_ADDR : 30'd0;
        MEM_WD     = issue_dbg ? DBG_WD : issue_data ? CPU_DATA_WD : 32'd0;
        CPU_RUN    = RESET && state == COMMIT;
    end

    // Datapath: latency counter, captured read data, commit counter and debug fairness token
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt         <= 2'd0;
            rd_q        <= 1'b0;
            dbg_turn    <= 1'b1;
            CPU_INST_RD <= '0;
            CPU_DATA_RD <= '0;
            DBG_RD      <= '0;
            DBG_ACK     <= 1'b0;
            INSTR_CNT   <= '0;
        end else begin
            cnt     <= MEM_EN ? LAT_M1 : done ? cnt : cnt - 2'd1;
            rd_q    <= MEM_EN ? !MEM_WE : rd_q;
            DBG_ACK <= state == DBGWAIT && done;
            if (state == FWAIT && done) CPU_INST_RD <= MEM_RD;
            if (state == DWAIT && done && rd_q) CPU_DATA_RD <= MEM_RD;
            if (state == DBGWAIT && done && rd_q) DBG_RD <= MEM_RD;
            if (state == DBGWAIT && done) dbg_turn <= 1'b0;
            if (state == COMMIT) begin
                INSTR_CNT <= INSTR_CNT + 1'b1;
                dbg_turn  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed checks of mem_sequencer at latency 1 (4-bit counter) and latency 3
module tb_mem_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] inst_addr = '0, data_addr = '0, dbg_addr = '0;
    logic        data_req = 1'b0, data_we = 1'b0, halt = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_wd = '0, dbg_wd = '0;

    logic [31:0] inst_rd_a, data_rd_a, dbg_rd_a, wd_a, rd_a;
    logic        run_a, ack_a, en_a, we_a;
    logic [3:0]  be_a, cnt_a;
    logic [29:0] addr_a;
    logic [31:0] inst_rd_b, data_rd_b, dbg_rd_b, wd_b, rd_b, cnt_b;
    logic        run_b, ack_b, en_b, we_b;
    logic [3:0]  be_b;
    logic [29:0] addr_b;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] pa [0:2];
    logic [31:0] pb [0:2];

    int checks = 0;
    int errors = 0;
    int we_cnt;

    always #5 clk = ~clk;

    mem_sequencer #(.MEM_LATENCY(1), .CNT_WIDTH(4)) dut_a (
        .CLK(clk), .RESET(rst_n), .CPU_INST_ADDR(inst_addr), .CPU_INST_RD(inst_rd_a),
        .CPU_DATA_REQ(data_req), .CPU_DATA_WE(data_we), .CPU_DATA_BE(data_be),
        .CPU_DATA_ADDR(data_addr), .CPU_DATA_WD(data_wd), .CPU_DATA_RD(data_rd_a),
        .CPU_RUN(run_a), .HALT(halt), .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_ADDR(dbg_addr),
        .DBG_WD(dbg_wd), .DBG_RD(dbg_rd_a), .DBG_ACK(ack_a), .MEM_EN(en_a), .MEM_WE(we_a),
        .MEM_BE(be_a), .MEM_ADDR(addr_a), .MEM_WD(wd_a), .MEM_RD(rd_a), .INSTR_CNT(cnt_a)
    );

    mem_sequencer #(.MEM_LATENCY(3)) dut_b (
        .CLK(clk), .RESET(rst_n), .CPU_INST_ADDR(inst_addr), .CPU_INST_RD(inst_rd_b),
        .CPU_DATA_REQ(data_req), .CPU_DATA_WE(data_we), .CPU_DATA_BE(data_be),
        .CPU_DATA_ADDR(data_addr), .CPU_DATA_WD(data_wd), .CPU_DATA_RD(data_rd_b),
        .CPU_RUN(run_b), .HALT(halt), .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_ADDR(dbg_addr),
        .DBG_WD(dbg_wd), .DBG_RD(dbg_rd_b), .DBG_ACK(ack_b), .MEM_EN(en_b), .MEM_WE(we_b),
        .MEM_BE(be_b), .MEM_ADDR(addr_b), .MEM_WD(wd_b), .MEM_RD(rd_b), .INSTR_CNT(cnt_b)
    );

    // RAM models: read data appears 1 (a) or 3 (b) cycles after the strobe
    always @(posedge clk) begin
        if (en_a) begin
            pa[0] <= mem_a[addr_a[7:0]];
            if (we_a) for (int i = 0; i < 4; i++) if (be_a[i]) mem_a[addr_a[7:0]][8*i +: 8] = wd_a[8*i +: 8];
        end
        if (en_b) begin
            pb[0] <= mem_b[addr_b[7:0]];
            if (we_b) for (int i = 0; i < 4; i++) if (be_b[i]) mem_b[addr_b[7:0]][8*i +: 8] = wd_b[8*i +: 8];
        end
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign rd_a = pa[0];
    assign rd_b = pb[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        tick();
        tick();
        chk({tag, "_rst_en"}, en_a, 0);
        chk({tag, "_rst_run"}, run_a, 0);
        chk({tag, "_rst_ack"}, ack_a, 0);
        chk({tag, "_rst_cnt"}, cnt_a, 0);
        chk({tag, "_rst_inst"}, inst_rd_a, 0);
        chk({tag, "_rst_data"}, data_rd_a, 0);
        chk({tag, "_rst_dbgrd"}, dbg_rd_a, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'hA000_0000 | i;
            mem_b[i] = 32'hA000_0000 | i;
        end
        mem_a[16] = 32'hDEAD_BEEF;
        mem_b[16] = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end

        // 1: plain fetch stream, 4 cycles per instruction
        do_reset("t1");
        inst_addr = 30'h40;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            chk("t1_en", en_a, c % 4 == 0);
            chk("t1_run", run_a, c % 4 == 3);
            if (c == 0) chk("t1_addr", addr_a, 30'h40);
        end
        tick();
        chk("t1_cnt", cnt_a, 3);
        chk("t1_inst", inst_rd_a, 32'hA000_0040);

        // 2: load, latency 1 and 3
        do_reset("t2");
        inst_addr = 30'h1;
        data_req = 1'b1;
        data_we = 1'b0;
        data_addr = 30'h10;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            chk("t2_run_a", run_a, c == 4);
            chk("t2_run_b", run_b, c == 8);
            if (c == 2) begin
                chk("t2_addr", addr_a, 30'h10);
                chk("t2_be", be_a, 4'hF);
                chk("t2_we", we_a, 0);
            end
            if (c == 4) chk("t2_data_a", data_rd_a, 32'hDEAD_BEEF);
            if (c == 8) chk("t2_data_b", data_rd_b, 32'hDEAD_BEEF);
        end

        // 3: partial store then debug readback under HALT
        do_reset("t3");
        inst_addr = 30'h2;
        data_req = 1'b1;
        data_we = 1'b1;
        data_be = 4'b0011;
        data_addr = 30'h20;
        data_wd = 32'h1234_5678;
        rst_n = 1'b1;
        #1;
        we_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            we_cnt += int'(we_a);
            if (c == 2) begin
                chk("t3_be", be_a, 4'b0011);
                chk("t3_wd", wd_a, 32'h1234_5678);
                chk("t3_addr", addr_a, 30'h20);
            end
            if (c == 4) chk("t3_run", run_a, 1);
        end
        chk("t3_we_pulses", we_cnt, 1);
        halt = 1'b1;
        data_req = 1'b0;
        tick();
        chk("t3_halt_idle", en_a, 0);
        dbg_req = 1'b1;
        dbg_we = 1'b0;
        dbg_addr = 30'h20;
        #1;
        chk("t3_dbg_en", en_a, 1);
        chk("t3_dbg_we", we_a, 0);
        tick();
        chk("t3_ack_early", ack_a, 0);
        tick();
        chk("t3_ack", ack_a, 1);
        chk("t3_dbg_rd", dbg_rd_a, 32'hA000_5678);
        dbg_req = 1'b0;
        tick();
        chk("t3_ack_once", ack_a, 0);
        chk("t3_no_run", run_a, 0);
        chk("t3_idle", en_a, 0);

        // 4: debug and CPU alternate while running
        do_reset("t4");
        halt = 1'b0;
        inst_addr = 30'h3;
        dbg_req = 1'b1;
        dbg_addr = 30'h30;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 18; c++) begin
            if (c > 0) tick();
            chk("t4_ack", ack_a, c % 6 == 2);
            chk("t4_run", run_a, c % 6 == 5);
            if (c == 2) chk("t4_dbg_rd", dbg_rd_a, 32'hA000_0030);
        end
        dbg_req = 1'b0;

        // 5: HALT gives back-to-back debug reads, release resumes fetch
        do_reset("t5");
        halt = 1'b1;
        dbg_req = 1'b1;
        dbg_addr = 30'h31;
        inst_addr = 30'h44;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            chk("t5_ack_a", ack_a, c >= 2 && c % 2 == 0);
            chk("t5_en_a", en_a, c % 2 == 0);
            chk("t5_run_a", run_a, 0);
            chk("t5_ack_b", ack_b, c == 4);
            chk("t5_run_b", run_b, 0);
        end
        tick();
        dbg_req = 1'b0;
        halt = 1'b0;
        #1;
        chk("t5_ack_a8", ack_a, 1);
        chk("t5_ack_b8", ack_b, 1);
        chk("t5_dbg_rd", dbg_rd_a, 32'hA000_0031);
        chk("t5_fetch_en_a", en_a, 1);
        chk("t5_fetch_addr_a", addr_a, 30'h44);
        chk("t5_fetch_en_b", en_b, 1);
        chk("t5_fetch_addr_b", addr_b, 30'h44);
        tick();
        tick();
        tick();
        chk("t5_resume_run", run_a, 1);

        // 6: reset during DWAIT, then counter wrap at 4 bits
        do_reset("t6");
        inst_addr = 30'h5;
        data_req = 1'b1;
        data_we = 1'b0;
        data_addr = 30'h10;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) tick();
        chk("t6_cnt_pre", cnt_a, 1);
        chk("t6_data_pre", data_rd_a, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        tick();
        chk("t6_run", run_a, 0);
        chk("t6_en", en_a, 0);
        chk("t6_cnt", cnt_a, 0);
        chk("t6_data", data_rd_a, 0);
        chk("t6_inst", inst_rd_a, 0);
        data_req = 1'b0;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 65; c++) begin
            if (c > 0) tick();
            if (c == 63) begin
                chk("t6_run15", run_a, 1);
                chk("t6_cnt15", cnt_a, 15);
            end
            if (c == 64) chk("t6_wrap", cnt_a, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
